// File: rtl/dtc_pkg.sv
// Shared constants, cfg_sel encoding and width helpers for the decision-tree classifier pipeline.
package dtc_pkg;

    localparam int DTC_N_FEAT_DEF  = 11;
    localparam int DTC_DEPTH_DEF   = 4;
    localparam int DTC_CLASS_W_DEF = 1;

    typedef enum logic {
        DTC_SEL_NODE = 1'b0,
        DTC_SEL_LEAF = 1'b1
    } dtc_sel_e;

    // A feature index needs at least one bit even for a single-feature vector.
    function automatic int dtc_fidx_w(input int n_feat);
        return (n_feat < 2) ? 1 : $clog2(n_feat);
    endfunction

    function automatic int dtc_cfg_w(input int n_feat, input int class_w);
        int f;
        f = dtc_fidx_w(n_feat);
        return (f > class_w) ? f : class_w;
    endfunction

endpackage

// File: rtl/dtc_level_stage.sv
// One tree level: picks the feature bit addressed by this level's node, extends the path index,
// and registers valid/feature/index for the next level.
module dtc_level_stage
    import dtc_pkg::*;
#(
    parameter int K      = 0,
    parameter int N_FEAT = DTC_N_FEAT_DEF,
    parameter int DEPTH  = DTC_DEPTH_DEF,
    parameter int FIDX_W = dtc_fidx_w(N_FEAT)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          i_adv,
    input  logic [(1<<K)-1:0][FIDX_W-1:0] i_lvl_fidx,
    input  logic                          i_valid,
    input  logic [N_FEAT-1:0]             i_feat,
    input  logic [DEPTH-1:0]              i_idx,
    output logic                          o_valid,
    output logic [N_FEAT-1:0]             o_feat,
    output logic [DEPTH-1:0]              o_idx
);

    localparam int N_NODE = 1 << K;
    localparam int PAD_W  = 1 << FIDX_W;

    logic [FIDX_W-1:0] w_fidx;
    logic [PAD_W-1:0]  w_feat_pad;
    logic              w_bit;
    logic [DEPTH-1:0]  w_idx_nxt;

    logic              r_valid;
    logic [N_FEAT-1:0] r_feat;
    logic [DEPTH-1:0]  r_idx;

    // NOTE: default assigned before the loop so every path drives w_fidx and no latch is inferred.
    always_comb begin
        w_fidx = '0;
        for (int j = 0; j < N_NODE; j++) begin
            if (i_idx == DEPTH'(j)) w_fidx = i_lvl_fidx[j];
        end
    end

    // Zero padding makes any index >= N_FEAT read a 0 bit.
    assign w_feat_pad = PAD_W'(i_feat);
    assign w_bit      = w_feat_pad[w_fidx];
    assign w_idx_nxt  = (i_idx << 1) | DEPTH'(w_bit);

    // NOTE: state registers use non-blocking assignments so all stages sample the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_feat  <= '0;
            r_idx   <= '0;
        end else if (i_adv) begin
            r_valid <= i_valid;
            r_feat  <= i_feat;
            r_idx   <= w_idx_nxt;
        end
    end

    assign o_valid = r_valid;
    assign o_feat  = r_feat;
    assign o_idx   = r_idx;

endmodule

// File: rtl/dtc_pipe_engine.sv
// Pipelined binary decision-tree classifier, one tree level per stage plus a leaf/output register.
// Optional handshake counter output stat_cnt is built when DTC_STATS_EN is defined.
module dtc_pipe_engine
    import dtc_pkg::*;
#(
    parameter int N_FEAT  = DTC_N_FEAT_DEF,
    parameter int DEPTH   = DTC_DEPTH_DEF,
    parameter int CLASS_W = DTC_CLASS_W_DEF
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 in_valid,
    output logic                                 in_ready,
    input  logic [N_FEAT-1:0]                    in_feat,
    output logic                                 out_valid,
    input  logic                                 out_ready,
    output logic [CLASS_W-1:0]                   out_class,
    input  logic                                 cfg_we,
    input  logic                                 cfg_sel,
    input  logic [DEPTH-1:0]                     cfg_addr,
    input  logic [dtc_cfg_w(N_FEAT,CLASS_W)-1:0] cfg_data,
    output logic                                 cfg_ready
`ifdef DTC_STATS_EN
    ,
    output logic [15:0]                          stat_cnt
`endif
);

    localparam int FIDX_W  = dtc_fidx_w(N_FEAT);
    localparam int N_NODES = (1 << DEPTH) - 1;
    localparam int N_LEAF  = 1 << DEPTH;

    logic [N_NODES-1:0][FIDX_W-1:0] r_node_tbl;
    logic [N_LEAF-1:0][CLASS_W-1:0] r_leaf_tbl;
    logic                           r_out_valid;
    logic [CLASS_W-1:0]             r_out_class;

    logic                           w_adv;
    logic                           w_cfg_ready;
    logic [DEPTH:0]                 w_valid;
    logic [N_FEAT-1:0]              w_feat [DEPTH+1];
    logic [DEPTH-1:0]               w_idx  [DEPTH+1];

    assign w_adv       = !r_out_valid || out_ready;
    assign in_ready    = w_adv && !cfg_we;
    assign w_cfg_ready = !(|w_valid[DEPTH:1]) && !r_out_valid;
    assign cfg_ready   = w_cfg_ready;

    assign w_valid[0] = in_valid && in_ready;
    assign w_feat[0]  = in_feat;
    assign w_idx[0]   = '0;

    // Stage k sees only the 2^k node entries of its own level (heap slice 2^k-1 .. 2^(k+1)-2).
    for (genvar k = 0; k < DEPTH; k++) begin : g_lvl
        dtc_level_stage #(
            .K      (k),
            .N_FEAT (N_FEAT),
            .DEPTH  (DEPTH),
            .FIDX_W (FIDX_W)
        ) u_stage (
            .clk        (clk),
            .rst_n      (rst_n),
            .i_adv      (w_adv),
            .i_lvl_fidx (r_node_tbl[(2<<k)-2 : (1<<k)-1]),
            .i_valid    (w_valid[k]),
            .i_feat     (w_feat[k]),
            .i_idx      (w_idx[k]),
            .o_valid    (w_valid[k+1]),
            .o_feat     (w_feat[k+1]),
            .o_idx      (w_idx[k+1])
        );
    end

    // NOTE: the tables are reset explicitly because a reset must leave every vector classifying to 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_node_tbl <= '0;
            r_leaf_tbl <= '0;
        end else if (cfg_we && w_cfg_ready) begin
            if (cfg_sel == DTC_SEL_NODE) begin
                // Only the all-ones address lies past the 2^DEPTH-1 node entries.
                if (cfg_addr != {DEPTH{1'b1}}) r_node_tbl[cfg_addr] <= cfg_data[FIDX_W-1:0];
            end else begin
                r_leaf_tbl[cfg_addr] <= cfg_data[CLASS_W-1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_class <= '0;
        end else if (w_adv) begin
            r_out_valid <= w_valid[DEPTH];
            if (w_valid[DEPTH]) r_out_class <= r_leaf_tbl[w_idx[DEPTH]];
        end
    end

    assign out_valid = r_out_valid;
    assign out_class = r_out_class;

`ifdef DTC_STATS_EN
    logic [15:0] r_stat_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stat_cnt <= '0;
        end else if (r_out_valid && out_ready && (r_stat_cnt != 16'hFFFF)) begin
            r_stat_cnt <= r_stat_cnt + 16'd1;
        end
    end

    assign stat_cnt = r_stat_cnt;
`endif

endmodule

// File: tb/tb_dtc_pipe_engine.sv
// Directed bench for dtc_pipe_engine (N_FEAT=11, DEPTH=4, CLASS_W=1); the stat_cnt checks are
// compiled in only when DTC_STATS_EN is defined.
module tb_dtc_pipe_engine;
    import dtc_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [10:0] in_feat;
    logic        out_valid;
    logic        out_ready;
    logic [0:0]  out_class;
    logic        cfg_we;
    logic        cfg_sel;
    logic [3:0]  cfg_addr;
    logic [3:0]  cfg_data;
    logic        cfg_ready;
`ifdef DTC_STATS_EN
    logic [15:0] stat_cnt;
`endif

    dtc_pipe_engine #(
        .N_FEAT  (11),
        .DEPTH   (4),
        .CLASS_W (1)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_feat   (in_feat),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_class (out_class),
        .cfg_we    (cfg_we),
        .cfg_sel   (cfg_sel),
        .cfg_addr  (cfg_addr),
        .cfg_data  (cfg_data),
        .cfg_ready (cfg_ready)
`ifdef DTC_STATS_EN
        ,
        .stat_cnt  (stat_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [10:0] feat;
        logic        exp;
    } vec_t;

    vec_t        vecs [10];
    int          node_b [15];
    logic [15:0] leaf_b;

    logic [10:0] q_feat [$];
    logic        q_exp  [$];
    logic        q_got  [$];

    int   n_checks = 0;
    int   n_errors = 0;
    logic saw_block;
    logic hold_pend;
    logic held_class;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Results are collected at each accepting edge, in order.
    always @(posedge clk) begin
        if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) q_got.push_back(out_class[0]);
    end

    // A held result must stay unchanged until it is taken.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_pend <= 1'b0;
        end else begin
            if (hold_pend) check("hold_stable", {30'd0, out_valid, out_class}, {30'd0, 1'b1, held_class});
            hold_pend  <= out_valid && !out_ready;
            held_class <= out_class[0];
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_write(input logic sel, input logic [3:0] addr, input logic [3:0] data);
        cfg_we   = 1'b1;
        cfg_sel  = sel;
        cfg_addr = addr;
        cfg_data = data;
        tick();
        cfg_we = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        for (int c = 0; c < 64 && !(cfg_ready && !out_valid); c++) tick();
        check(name, {31'd0, cfg_ready}, 32'd1);
    endtask

    // Streams q_feat back to back; out_ready is low for stall_len cycles from stall_from.
    task automatic stream(input string name, input int stall_from, input int stall_len);
        int   tx;
        int   n;
        logic acc;
        n = q_feat.size();
        tx = 0;
        saw_block = 1'b0;
        q_got.delete();
        for (int cyc = 0; cyc < 200 && (tx < n || q_got.size() < n); cyc++) begin
            in_valid  = (tx < n);
            in_feat   = (tx < n) ? q_feat[tx] : 11'h000;
            out_ready = !(cyc >= stall_from && cyc < stall_from + stall_len);
            #1;
            if (in_valid && !in_ready) saw_block = 1'b1;
            acc = in_valid && in_ready;
            @(posedge clk);
            #1;
            if (acc) tx++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check({name, "_count"}, q_got.size(), n);
        for (int i = 0; i < n && i < q_got.size(); i++)
            check($sformatf("%s_%0d", name, i), {31'd0, q_got[i]}, {31'd0, q_exp[i]});
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_feat = '0; out_ready = 1'b1;
        cfg_we = 1'b0; cfg_sel = 1'b0; cfg_addr = '0; cfg_data = '0;

        vecs[0] = '{"all0",  11'h000, 1'b1};
        vecs[1] = '{"all1",  11'h7FF, 1'b1};
        vecs[2] = '{"f001",  11'h001, 1'b1};
        vecs[3] = '{"f021",  11'h021, 1'b0};
        vecs[4] = '{"f00a",  11'h00A, 1'b0};
        vecs[5] = '{"f212",  11'h212, 1'b1};
        vecs[6] = '{"f088",  11'h088, 1'b0};
        vecs[7] = '{"f080",  11'h080, 1'b1};
        vecs[8] = '{"f7fe",  11'h7FE, 1'b1};
        vecs[9] = '{"f005",  11'h005, 1'b0};
        node_b = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 13, 0, 1, 2};
        leaf_b = 16'hA5C3;

        // Reset state and first-result latency with cleared tables.
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_class", {31'd0, out_class}, 32'd0);
        #2 rst_n = 1'b1;
        tick();
        check("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("post_rst_cfg_ready", {31'd0, cfg_ready}, 32'd1);
        in_valid = 1'b1;
        in_feat  = 11'h7FF;
        tick();
        in_valid = 1'b0;
        check("inflight_cfg_ready", {31'd0, cfg_ready}, 32'd0);
        for (int e = 1; e <= 4; e++) begin
            tick();
            check($sformatf("lat_valid_e%0d", e), {31'd0, out_valid}, {31'd0, e == 4});
        end
        check("lat_class", {31'd0, out_class}, 32'd0);
        tick();
        check("lat_taken", {31'd0, out_valid}, 32'd0);

        // All nodes test feature 1, only leaf 15 labelled 1.
        wait_idle("idle_a");
        for (int a = 0; a < 15; a++) cfg_write(DTC_SEL_NODE, 4'(a), 4'd1);
        cfg_write(DTC_SEL_LEAF, 4'd15, 4'd1);
        cfg_write(DTC_SEL_NODE, 4'd15, 4'd0);
        q_feat = '{11'h002, 11'h7FD};
        q_exp  = '{1'b1, 1'b0};
        stream("cfg_a", 1000, 0);

        // Mixed tree; the final leaf write coincides with an offered vector.
        wait_idle("idle_b");
        for (int a = 0; a < 15; a++) cfg_write(DTC_SEL_NODE, 4'(a), 4'(node_b[a]));
        for (int a = 0; a < 15; a++) cfg_write(DTC_SEL_LEAF, 4'(a), {3'd0, leaf_b[a]});
        in_valid = 1'b1;
        in_feat  = 11'h7FF;
        cfg_we = 1'b1; cfg_sel = DTC_SEL_LEAF; cfg_addr = 4'd15; cfg_data = {3'd0, leaf_b[15]};
        #1;
        check("cfg_wins_in_ready", {31'd0, in_ready}, 32'd0);
        tick();
        cfg_we = 1'b0;
        in_valid = 1'b0;
        check("cfg_wins_not_taken", {31'd0, cfg_ready}, 32'd1);

        q_feat.delete();
        q_exp.delete();
        for (int i = 0; i < 10; i++) begin
            q_feat.push_back(vecs[i].feat);
            q_exp.push_back(vecs[i].exp);
        end
        stream("table", 1000, 0);

        // Six back-to-back vectors with a three-cycle downstream stall.
        q_feat.delete();
        q_exp.delete();
        for (int i = 2; i < 8; i++) begin
            q_feat.push_back(vecs[i].feat);
            q_exp.push_back(vecs[i].exp);
        end
        stream("stall", 4, 3);
        check("stall_in_ready_drop", {31'd0, saw_block}, 32'd1);

        // Writes attempted while two vectors are in flight must be dropped.
        wait_idle("idle_c");
        q_got.delete();
        in_valid = 1'b1; in_feat = 11'h021;
        tick();
        in_feat = 11'h000;
        tick();
        in_valid = 1'b0;
        cfg_we = 1'b1; cfg_sel = DTC_SEL_LEAF; cfg_addr = 4'd11; cfg_data = 4'd1;
        #1;
        check("busy_cfg_ready", {31'd0, cfg_ready}, 32'd0);
        check("busy_in_ready", {31'd0, in_ready}, 32'd0);
        tick();
        cfg_addr = 4'd0; cfg_data = 4'd0;
        tick();
        cfg_we = 1'b0;
        for (int c = 0; c < 20 && q_got.size() < 2; c++) tick();
        check("busy_count", q_got.size(), 2);
        if (q_got.size() >= 2) begin
            check("busy_res0", {31'd0, q_got[0]}, 32'd0);
            check("busy_res1", {31'd0, q_got[1]}, 32'd1);
        end
        q_feat = '{11'h021, 11'h000};
        q_exp  = '{1'b0, 1'b1};
        stream("busy_after", 1000, 0);

        // Out-of-range root feature index reads as 0.
        wait_idle("idle_d");
        cfg_write(DTC_SEL_NODE, 4'd0, 4'd13);
        q_feat = '{11'h003, 11'h002, 11'h000};
        q_exp  = '{1'b0, 1'b0, 1'b1};
        stream("root_oor", 1000, 0);

        // Reset while a result is held and more are in flight.
        in_valid = 1'b1; in_feat = 11'h7FF; out_ready = 1'b0;
        repeat (3) tick();
        in_valid = 1'b0;
        repeat (3) tick();
        check("pre_rst_held", {31'd0, out_valid}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("async_rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("async_rst_cfg_ready", {31'd0, cfg_ready}, 32'd1);
        check("async_rst_out_class", {31'd0, out_class}, 32'd0);
`ifdef DTC_STATS_EN
        check("async_rst_stat_cnt", {16'd0, stat_cnt}, 32'd0);
`endif
        #5 rst_n = 1'b1;
        out_ready = 1'b1;
        tick();
        check("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("mid_rst_cfg_ready", {31'd0, cfg_ready}, 32'd1);
        q_feat = '{11'h7FF, 11'h7FF, 11'h7FF, 11'h7FF, 11'h7FF};
        q_exp  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        stream("cleared", 1000, 0);
`ifdef DTC_STATS_EN
        check("stat_cnt_5", {16'd0, stat_cnt}, 32'd5);
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/dtc_pipe_engine.md
DTC_PIPE_ENGINE -- requirements
Module: dtc_pipe_engine

Interface
REQ-001 SHALL have parameter N_FEAT, default 11, meaning the width of the binary feature vector.
REQ-002 SHALL have parameter DEPTH, default 4, meaning the number of tree levels (1..8).
REQ-003 SHALL have parameter CLASS_W, default 1, meaning the width of the class label.
REQ-004 SHALL have port clk, input, 1, the single clock; all logic rising-edge.
REQ-005 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port in_valid, input, 1, meaning a feature vector is offered.
REQ-007 SHALL have port in_ready, output, 1, meaning the vector is accepted this cycle.
REQ-008 SHALL have port in_feat, input, N_FEAT, the feature vector.
REQ-009 SHALL have port out_valid, output, 1, meaning a result is held.
REQ-010 SHALL have port out_ready, input, 1, the downstream accept.
REQ-011 SHALL have port out_class, output, CLASS_W, the result label.
REQ-012 SHALL have port cfg_we, input, 1, the table write strobe.
REQ-013 SHALL have port cfg_sel, input, 1, selecting the table: 0 = node table, 1 = leaf table.
REQ-014 SHALL have port cfg_addr, input, DEPTH, the table index.
REQ-015 SHALL have port cfg_data, input, max(FIDX_W,CLASS_W), the table data; FIDX_W = clog2(N_FEAT).
REQ-016 SHALL have port cfg_ready, output, 1, meaning the pipeline is empty and writes are accepted.

Function
REQ-017 SHALL hold a node table of 2^DEPTH-1 feature indices (heap order: root 0, children 2i+1 for bit 0 and 2i+2 for bit 1) and a leaf table of 2^DEPTH labels.
REQ-018 SHALL evaluate level k in pipeline stage k: take the bit feat[node_fidx], then next_idx = 2*idx + bit; the leaf index selects out_class.
REQ-019 SHALL treat a feature index >= N_FEAT as selecting bit value 0.
REQ-020 SHALL define advance = !out_valid || out_ready, with the whole pipeline stalling together when advance = 0.
REQ-021 SHALL drive in_ready = advance && !cfg_we.
REQ-022 SHALL assert out_valid for a vector accepted at edge E after edge E+DEPTH when there is no stall, with each stall cycle adding one cycle.
REQ-023 SHALL sustain throughput of 1 vector per cycle, deliver results in acceptance order, and never drop or duplicate a result.
REQ-024 SHALL hold out_class and out_valid stable while out_valid=1 and out_ready=0.
REQ-025 SHALL drive cfg_ready = 1 only when all stage valids and out_valid are 0.
REQ-026 SHALL apply cfg_we when cfg_ready=1 at the next edge; cfg_we with cfg_ready=0 SHALL be ignored.
REQ-027 SHALL let cfg_we win when cfg_we and in_valid are asserted in the same cycle; the vector is not accepted (in_ready=0).
REQ-028 SHALL ignore a cfg_addr beyond the table size, with no table change.

Reset
REQ-029 SHALL, on rst_n low, immediately clear all stage valids and out_valid, set out_class=0, clear node tables to 0 and leaf tables to 0, independent of clk.
REQ-030 SHALL lose in-flight vectors on reset mid-operation; after release, every vector classifies to 0 until the tables are reprogrammed.
REQ-031 SHALL hold in_ready=1 and cfg_ready=1 from the first cycle after reset release.

Configuration
REQ-032 SHALL, with macro DTC_STATS_EN defined, add an output port stat_cnt of width 16 that counts out_valid && out_ready handshakes, saturates at 16'hFFFF and is cleared by reset.
REQ-033 SHALL, without DTC_STATS_EN, have no stat_cnt port and no counter logic.

Structure
REQ-034 SHALL use package dtc_pkg to hold the default parameter constants, the cfg_sel encoding constants (DTC_SEL_NODE=0, DTC_SEL_LEAF=1) and the clog2-based width helper functions.
REQ-035 SHALL use one sub-module, dtc_level_stage (parameterised by level k), holding the per-level bit select, index update and valid/feature/index registers; the top instantiates DEPTH copies via generate.

Verification (N_FEAT=11, DEPTH=4, CLASS_W=1)
REQ-036 SHALL cover: reset, then in_feat=11'h7FF accepted at edge 0 -> out_valid=1 after edge 4, out_class=0.
REQ-037 SHALL cover: program all nodes fidx=1 and leaf[15]=1, others 0; in_feat=11'h002 -> out_class=1; in_feat=11'h7FD -> out_class=0.
REQ-038 SHALL cover: 6 back-to-back vectors with out_ready=0 for 3 cycles -> in_ready drops, all 6 results arrive in order with none lost.
REQ-039 SHALL cover: cfg_we while 2 vectors are in flight -> cfg_ready=0, table unchanged, results match the old table.
REQ-040 SHALL cover: root fidx=13 (out of range) -> root bit taken as 0 regardless of in_feat.
REQ-041 SHALL cover, with DTC_STATS_EN: 5 completed handshakes -> stat_cnt=5; rst_n pulse mid-stream -> stat_cnt=0, out_valid=0 immediately.
